// File: rtl/bm_dag_sched.sv
// Round-robin scheduler feeding a 2-stage shared logic unit with run/drain/halt control.
// Optional DAG_SCHED_PRIO_EN: requester 0 gets absolute priority over the rotation.
module bm_dag_sched #(
  parameter int BITS = 2,
  parameter int NREQ = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 run,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*BITS-1:0] a_in,
  input  logic [NREQ*BITS-1:0] b_in,
  input  logic [2*NREQ-1:0]    op_in,
  output logic [NREQ-1:0]      gnt,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [BITS-1:0]      res_data,
  output logic [1:0]           res_tag,
  output logic                 busy,
  output logic                 halted
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, HALT} state_t;

  state_t          state;
  logic [1:0]      ptr;
  logic            s1_v, s2_v;
  logic [BITS-1:0] s1_a, s1_b;
  logic [1:0]      s1_op, s1_t;
  logic [BITS-1:0] s2_d;
  logic [1:0]      s2_t;

  logic       xfer, s2_ld, s1_acc;
  logic       grant_ok, found, do_gnt;
  logic [1:0] idx, gidx;
  logic       s1_nv, s2_nv;

  function automatic logic [BITS-1:0] alu(
    input logic [1:0]      op,
    input logic [BITS-1:0] a,
    input logic [BITS-1:0] b
  );
    logic [BITS-1:0] r;
    unique case (op)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = a ^ b;
      default: r = a & ~b;
    endcase
    return r;
  endfunction

  assign xfer   = s2_v && res_ready;
  assign s2_ld  = s1_v && (!s2_v || xfer);
  assign s1_acc = !s1_v || s2_ld;

  // reset_n gates the grant so gnt drops at once on an async reset
  assign grant_ok = reset_n && run && s1_acc &&
                    (state == IDLE || state == ACTIVE);

  always_comb begin
    found = 1'b0;
    gidx  = 2'd0;
    idx   = 2'd0;
`ifdef DAG_SCHED_PRIO_EN
    if (req[0]) begin
      found = 1'b1;
      gidx  = 2'd0;
    end
`endif
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
  end

  assign do_gnt = grant_ok && found;
  assign gnt    = do_gnt ? ({{(NREQ-1){1'b0}}, 1'b1} << gidx) : '0;

  assign s1_nv = s1_v && !s2_ld;
  assign s2_nv = s2_ld || (s2_v && !xfer);

  assign res_valid = s2_v;
  assign res_data  = s2_d;
  assign res_tag   = s2_t;
  assign busy      = s1_v || s2_v;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr   <= '0;
      s1_v  <= 1'b0;
      s1_a  <= '0;
      s1_b  <= '0;
      s1_op <= '0;
      s1_t  <= '0;
      s2_v  <= 1'b0;
      s2_d  <= '0;
      s2_t  <= '0;
    end else begin
      if (s2_ld) begin
        s2_v <= 1'b1;
        s2_d <= alu(s1_op, s1_a, s1_b);
        s2_t <= s1_t;
      end else if (xfer) begin
        s2_v <= 1'b0;
      end
      if (do_gnt) begin
        s1_v  <= 1'b1;
        s1_a  <= a_in[int'(gidx)*BITS +: BITS];
        s1_b  <= b_in[int'(gidx)*BITS +: BITS];
        s1_op <= op_in[int'(gidx)*2 +: 2];
        s1_t  <= gidx;
`ifdef DAG_SCHED_PRIO_EN
        if (gidx != 2'd0) ptr <= gidx + 2'd1;
`else
        ptr <= gidx + 2'd1;
`endif
      end else if (s2_ld) begin
        s1_v <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      halted <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!run) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (do_gnt) begin
            state <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (!run) state <= DRAIN;
          else if (!s1_v && !s2_v && !do_gnt) state <= IDLE;
        end
        DRAIN: begin
          if (!s1_nv && !s2_nv) begin
            state  <= HALT;
            halted <= 1'b1;
          end
        end
        HALT: begin
          if (run) begin
            state  <= IDLE;
            halted <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
